// File: rtl/keycode_evt_pkg.sv
// Shared types for the keycode event scheduler: event encodings, FSM states
// and the "no key" keycode.
package keycode_evt_pkg;

   typedef enum logic [1:0] {
      EV_NONE    = 2'b00,
      EV_PRESS   = 2'b01,
      EV_RELEASE = 2'b10,
      EV_REPEAT  = 2'b11
   } ev_type_t;

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT,
      SWAP
   } state_t;

   localparam logic [7:0] KEY_NONE = 8'h00;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO; a push into a full FIFO with no same-cycle
// pop is dropped and latches the sticky overflow flag.
module sync_fifo_fwft #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             clr_overflow,
   output logic             overflow
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] last_q;
   logic             empty;
   logic             full;
   logic             pop;
   logic             wr_en;
   logic             drop;

   assign empty     = (count == '0);
   assign full      = (count == CW'(DEPTH));
   assign pop       = out_valid & out_ready;
   assign wr_en     = push & (~full | pop);
   assign drop      = push & full & ~pop;
   assign out_valid = ~empty;
   // When empty, keep presenting the most recently popped entry.
   assign out_data  = empty ? last_q : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         last_q   <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            last_q <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop)
            overflow <= 1'b1;
         else if (clr_overflow)
            overflow <= 1'b0;
      end
   end

endmodule

// File: rtl/keycode_event_scheduler.sv
// Turns the raw keycode level into debounced PRESS/RELEASE/REPEAT events,
// queued in a small FWFT FIFO for the game logic.
module keycode_event_scheduler
   import keycode_evt_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 4,
   parameter int REPEAT_DELAY = 25000000,
   parameter int REPEAT_RATE  = 5000000,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [7:0] keycode,
   input  logic       enable,
   output logic       ev_valid,
   input  logic       ev_ready,
   output logic [7:0] ev_code,
   output logic [1:0] ev_type,
   output logic [7:0] cur_key,
   output logic       overflow,
   input  logic       clr_overflow,
   output state_t     dbg_state
);

   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW      = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

   logic [7:0]    sample_q;
   logic [7:0]    cand_q;
   logic [7:0]    db_cnt;
   logic          accept;
   state_t        state;
   logic [RW-1:0] rpt_cnt;
   logic          push;
   ev_type_t      push_type;
   logic [7:0]    push_code;
   logic [9:0]    head;

   // A candidate held for DEBOUNCE_CYC samples that differs from cur_key is a new key level.
   assign accept = (db_cnt == 8'(DEBOUNCE_CYC)) && (cand_q != cur_key);

   always_comb begin
      push      = 1'b0;
      push_type = EV_NONE;
      push_code = KEY_NONE;
      if (enable) begin
         if (state == SWAP) begin
            // The pending PRESS goes out unless the key was already dropped again.
            if (!(accept && cand_q == KEY_NONE)) begin
               push      = 1'b1;
               push_type = EV_PRESS;
               push_code = accept ? cand_q : cur_key;
            end
         end else if (accept) begin
            push      = 1'b1;
            push_type = (cur_key == KEY_NONE) ? EV_PRESS : EV_RELEASE;
            push_code = (cur_key == KEY_NONE) ? cand_q : cur_key;
         end else if ((state == DELAY && rpt_cnt == RW'(REPEAT_DELAY - 1)) ||
                      (state == REPEAT && rpt_cnt == RW'(REPEAT_RATE - 1))) begin
            push      = 1'b1;
            push_type = EV_REPEAT;
            push_code = cur_key;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         sample_q <= KEY_NONE;
         cand_q   <= KEY_NONE;
         db_cnt   <= '0;
         cur_key  <= KEY_NONE;
         state    <= IDLE;
         rpt_cnt  <= '0;
      end else begin
         sample_q <= keycode;
         if (sample_q != cand_q) begin
            cand_q <= sample_q;
            db_cnt <= 8'd1;
         end else if (db_cnt < 8'(DEBOUNCE_CYC)) begin
            db_cnt <= db_cnt + 8'd1;
         end
         if (accept)
            cur_key <= cand_q;

         if (!enable) begin
            state   <= IDLE;
            rpt_cnt <= '0;
         end else if (state == SWAP || accept) begin
            rpt_cnt <= '0;
            if (accept && cand_q == KEY_NONE)
               state <= IDLE;
            else if (state == SWAP || cur_key == KEY_NONE)
               state <= DELAY;
            else
               state <= SWAP;
         end else begin
            case (state)
               DELAY: begin
                  if (rpt_cnt == RW'(REPEAT_DELAY - 1)) begin
                     rpt_cnt <= '0;
                     state   <= REPEAT;
                  end else begin
                     rpt_cnt <= rpt_cnt + 1'b1;
                  end
               end
               REPEAT: begin
                  if (rpt_cnt == RW'(REPEAT_RATE - 1))
                     rpt_cnt <= '0;
                  else
                     rpt_cnt <= rpt_cnt + 1'b1;
               end
               default: rpt_cnt <= '0;
            endcase
         end
      end
   end

   assign dbg_state = state;

   // Handshake: the head event transfers on a rising edge where ev_valid and ev_ready are both 1;
   // ev_valid never depends on ev_ready, and ev_code/ev_type stay stable while ev_valid=1 and ev_ready=0.
   sync_fifo_fwft #(
      .WIDTH(10),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk          (Clk),
      .rst          (Reset),
      .push         (push),
      .push_data    ({push_type, push_code}),
      .out_valid    (ev_valid),
      .out_ready    (ev_ready),
      .out_data     (head),
      .clr_overflow (clr_overflow),
      .overflow     (overflow)
   );

   assign ev_type = head[9:8];
   assign ev_code = head[7:0];

endmodule
